// File: rtl/dmem_dump_pkg.sv
// Shared definitions for the data-memory dump reader.
//   - state_e        : dump sequencer states
//   - WORD_BYTES     : byte stride between consecutive data-memory words
//   - word_byte_addr : byte address of word 'idx' relative to 'base'
//                      (64-bit result; callers truncate to their address width,
//                      which gives the modulo-2^ADDR_W wrap)
package dmem_dump_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_CAPTURE,
    S_SEND,
    S_FINISH
  } state_e;

  localparam int unsigned WORD_BYTES = 4;

  function automatic logic [63:0] word_byte_addr(input logic [63:0] base,
                                                 input int unsigned idx);
    return base + 64'(WORD_BYTES) * 64'(idx);
  endfunction

endpackage

// File: rtl/dmem_dump_reader_if.sv
// Valid/ready stream carrying (address, data) beats out of the dump reader.
//   out_valid : beat valid (master -> slave)
//   out_ready : beat accepted at the clock edge (slave -> master)
//   out_addr  : byte address of the word in this beat
//   out_data  : word contents
//   out_last  : marks the final word of the dump
interface dmem_dump_reader_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
);
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_addr;
  logic [DATA_W-1:0] out_data;
  logic              out_last;

  modport master (output out_valid, output out_addr, output out_data,
                  output out_last, input out_ready);
  modport slave  (input out_valid, input out_addr, input out_data,
                  input out_last, output out_ready);
endinterface

// File: rtl/dmem_dump_reader_stream_hold_reg.sv
// Output register for a valid/ready stream.
// Loads a beat when empty, holds it unchanged until the consumer accepts it,
// then clears valid. Payload is only rewritten by a load.
//   clk, reset        : clock, synchronous active-low reset
//   load_i            : capture addr_i/data_i/last_i (honoured only when empty)
//   ready_i           : consumer accepts the held beat
//   valid_o..last_o   : registered beat presented downstream
module stream_hold_reg #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              last_i,
  input  logic              ready_i,
  output logic              valid_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] data_o,
  output logic              last_o
);

  logic              valid_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              last_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else if (load_i && !valid_q) begin
      valid_q <= 1'b1;
      addr_q  <= addr_i;
      data_q  <= data_i;
      last_q  <= last_i;
    end else if (valid_q && ready_i) begin
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign addr_o  = addr_q;
  assign data_o  = data_q;
  assign last_o  = last_q;

endmodule

// File: rtl/dmem_dump_reader.sv
// Streams WORDS data-memory words starting at byte address BASE out as
// (address, data) beats. One word per READ -> CAPTURE -> SEND round trip,
// so the read port is strobed exactly once per beat.
//   clk, reset : clock, synchronous active-low reset (aborts a dump at once)
//   start      : begin a dump (only looked at in IDLE)
//   busy       : dump in progress (READ/CAPTURE/SEND/FINISH)
//   done       : one-cycle pulse after the last beat is accepted
//   mem_re     : read strobe, one cycle per word
//   mem_addr   : word-aligned byte address for the read
//   mem_rdata  : read data, valid the cycle after mem_re
//   out_if     : beat stream (master side)
module dmem_dump_reader
  import dmem_dump_pkg::*;
#(
  parameter int unsigned       DATA_W = 32,
  parameter int unsigned       ADDR_W = 32,
  parameter logic [ADDR_W-1:0] BASE   = '0,
  parameter int unsigned       WORDS  = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                mem_re,
  output logic [ADDR_W-1:0]   mem_addr,
  input  logic [DATA_W-1:0]   mem_rdata,
  dmem_dump_reader_if.master  out_if
);

  // One spare bit so WORDS itself is representable; the index never wraps.
  localparam int unsigned IDX_W = $clog2(WORDS) + 1;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             load;
  logic             handshake;
  logic             is_last;

  assign handshake = (state_q == S_SEND) && out_if.out_valid && out_if.out_ready;
  assign is_last   = (idx_q == IDX_W'(WORDS - 1));

  // The address tracks the index at all times; the index is zero in IDLE so
  // the port rests at BASE, and it is unchanged in CAPTURE so the same value
  // is registered as the beat address.
  assign mem_addr = ADDR_W'(word_byte_addr(64'(BASE), 32'(idx_q)));
  assign mem_re   = (state_q == S_READ);
  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_FINISH);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    load    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_READ;
          idx_d   = '0;
        end
      end
      S_READ:    state_d = S_CAPTURE;
      S_CAPTURE: begin
        load    = 1'b1;
        state_d = S_SEND;
      end
      S_SEND: begin
        if (handshake) begin
          if (out_if.out_last) begin
            state_d = S_FINISH;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = S_READ;
          end
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  stream_hold_reg #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_hold (
    .clk     (clk),
    .reset   (reset),
    .load_i  (load),
    .addr_i  (mem_addr),
    .data_i  (mem_rdata),
    .last_i  (is_last),
    .ready_i (out_if.out_ready),
    .valid_o (out_if.out_valid),
    .addr_o  (out_if.out_addr),
    .data_o  (out_if.out_data),
    .last_o  (out_if.out_last)
  );

endmodule

// File: tb/tb_dmem_dump_reader.sv
module tb_dmem_dump_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_start, b_start;
  logic        a_busy, a_done, a_mem_re;
  logic        b_busy, b_done, b_mem_re;
  logic [31:0] a_mem_addr, b_mem_addr;
  logic [31:0] a_rdata, b_rdata;
  logic [31:0] ram [0:1023];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dmem_dump_reader_if #(.DATA_W(32), .ADDR_W(32)) a_if ();
  dmem_dump_reader_if #(.DATA_W(32), .ADDR_W(32)) b_if ();

  dmem_dump_reader #(.DATA_W(32), .ADDR_W(32), .BASE(32'h0), .WORDS(64)) u_a (
    .clk(clk), .reset(rst_n), .start(a_start), .busy(a_busy), .done(a_done),
    .mem_re(a_mem_re), .mem_addr(a_mem_addr), .mem_rdata(a_rdata), .out_if(a_if)
  );

  dmem_dump_reader #(.DATA_W(32), .ADDR_W(32), .BASE(32'h40), .WORDS(1)) u_b (
    .clk(clk), .reset(rst_n), .start(b_start), .busy(b_busy), .done(b_done),
    .mem_re(b_mem_re), .mem_addr(b_mem_addr), .mem_rdata(b_rdata), .out_if(b_if)
  );

  // Synchronous read ports: data one cycle after the strobe.
  always @(posedge clk) begin
    if (a_mem_re) a_rdata <= ram[a_mem_addr[11:2]];
    if (b_mem_re) b_rdata <= ram[b_mem_addr[11:2]];
  end

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One dump on DUT A. pct = percent of cycles with out_ready high.
  // spam: pulse start randomly while busy. abort_beat >= 0: reset in SEND of that beat.
  task automatic run_a(input int pct, input bit chk_lat, input bit spam, input int abort_beat);
    int n, beat, mre;
    bit pend, fin;
    logic [31:0] s_addr, s_data;
    logic        s_last;
    n = 0; beat = 0; mre = 0; pend = 0; fin = 0;
    s_addr = '0; s_data = '0; s_last = 1'b0;
    @(posedge clk); #1;
    a_start = 1'b1;
    a_if.out_ready = ($urandom_range(0, 99) < pct);
    while (!fin && n < 4000) begin
      @(posedge clk); n++; #1;
      a_start = spam ? (a_busy && ($urandom_range(0, 1) == 1)) : 1'b0;
      a_if.out_ready = ($urandom_range(0, 99) < pct);
      @(negedge clk);
      if (a_mem_re) mre++;
      if (abort_beat >= 0 && beat == abort_beat && a_if.out_valid) begin
        rst_n = 1'b0;
        @(posedge clk); #1;
        check_val("abort_valid", a_if.out_valid, 0);
        check_val("abort_busy", a_busy, 0);
        check_val("abort_done", a_done, 0);
        check_val("abort_mem_addr", a_mem_addr, 0);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          check_val("post_abort_done", a_done, 0);
          check_val("post_abort_valid", a_if.out_valid, 0);
        end
        return;
      end
      if (pend) begin
        check_val("hold_valid", a_if.out_valid, 1);
        check_val("hold_addr", a_if.out_addr, s_addr);
        check_val("hold_data", a_if.out_data, s_data);
        check_val("hold_last", a_if.out_last, s_last);
      end
      if (a_if.out_valid && a_if.out_ready) begin
        check_val("beat_addr", a_if.out_addr, 64'(beat * 4));
        check_val("beat_data", a_if.out_data, 64'(32'hA500_0000 + beat));
        check_val("beat_last", a_if.out_last, (beat == 63));
        beat++;
        pend = 0;
      end else if (a_if.out_valid) begin
        pend = 1;
        s_addr = a_if.out_addr; s_data = a_if.out_data; s_last = a_if.out_last;
      end
      if (a_done) fin = 1;
    end
    a_start = 1'b0;
    check_val("done_seen", fin, 1);
    check_val("beat_count", beat, 64);
    check_val("mem_re_count", mre, 64);
    if (chk_lat) check_val("start_to_done", n, 193);
    @(negedge clk);
    check_val("idle_busy", a_busy, 0);
    check_val("idle_done", a_done, 0);
    check_val("idle_mem_addr", a_mem_addr, 0);
  endtask

  task automatic run_b();
    int n, mre, hs_n, done_n;
    n = 0; mre = 0; hs_n = -1; done_n = -1;
    b_if.out_ready = 1'b1;
    @(posedge clk); #1;
    b_start = 1'b1;
    while (done_n < 0 && n < 100) begin
      @(posedge clk); n++; #1;
      b_start = 1'b0;
      @(negedge clk);
      if (b_mem_re) begin
        mre++;
        check_val("b_mem_addr", b_mem_addr, 32'h40);
      end
      if (b_if.out_valid && b_if.out_ready) begin
        check_val("b_addr", b_if.out_addr, 32'h40);
        check_val("b_data", b_if.out_data, 32'hA500_0010);
        check_val("b_last", b_if.out_last, 1);
        hs_n = n;
      end
      if (b_done) done_n = n;
    end
    check_val("b_mem_re_once", mre, 1);
    check_val("b_done_after_hs", done_n, hs_n + 1);
    check_val("b_start_to_done", done_n, 4);
  endtask

  // start held high across FINISH: next dump begins only from IDLE.
  task automatic run_hold_start();
    int n;
    bit fin;
    n = 0; fin = 0;
    a_if.out_ready = 1'b1;
    @(posedge clk); #1;
    a_start = 1'b1;
    while (!fin && n < 400) begin
      @(posedge clk); n++;
      @(negedge clk);
      if (a_done) fin = 1;
    end
    check_val("hs_first_done", fin, 1);
    check_val("hs_first_len", n, 193);
    @(negedge clk);
    check_val("hs_idle_busy", a_busy, 0);
    check_val("hs_idle_mem_re", a_mem_re, 0);
    @(negedge clk);
    check_val("hs_restart_busy", a_busy, 1);
    check_val("hs_restart_mem_re", a_mem_re, 1);
    check_val("hs_restart_addr", a_mem_addr, 0);
    a_start = 1'b0;
    fin = 0; n = 0;
    while (!fin && n < 400) begin
      @(negedge clk); n++;
      if (a_done) fin = 1;
    end
    check_val("hs_second_done", fin, 1);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = 32'hA500_0000 + i;
    rst_n = 1'b0;
    a_start = 1'b0; b_start = 1'b0;
    a_if.out_ready = 1'b0; b_if.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_busy", a_busy, 0);
    check_val("rst_done", a_done, 0);
    check_val("rst_mem_re", a_mem_re, 0);
    check_val("rst_valid", a_if.out_valid, 0);
    check_val("rst_last", a_if.out_last, 0);
    check_val("rst_mem_addr", a_mem_addr, 0);
    check_val("rst_out_addr", a_if.out_addr, 0);
    check_val("rst_out_data", a_if.out_data, 0);
    check_val("rst_b_mem_addr", b_mem_addr, 32'h40);
    @(posedge clk); #1;
    rst_n = 1'b1;

    run_a(100, 1, 0, -1);
    run_a(30, 0, 0, -1);
    run_b();
    run_a(100, 0, 0, 10);
    run_a(100, 1, 0, -1);
    run_a(60, 0, 1, -1);
    run_hold_start();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_dump_reader.md
Name: dmem_dump_reader

Overview:
- Hardware counterpart of the bench's post-run data-memory dump: reads a block of data-memory words and streams them out as (address, data) beats on a valid/ready interface.
- Lets silicon or FPGA builds extract RAM contents after the single-cycle core finishes, with no simulator file I/O.
- Sits beside the data memory on a dedicated synchronous read port; the core's store path (address_to_mem, data_to_mem, write_enable) is untouched.

Parameters:
- DATA_W, 32, data word width.
- ADDR_W, 32, byte-address width.
- BASE, 0, byte address of first word; must be 4-aligned.
- WORDS, 64, number of words dumped; legal range 1..1024; BASE+4*(WORDS-1) must fit in ADDR_W.

Ports:
- clk, in, 1, single clock; all state updates on rising edge.
- reset, in, 1, synchronous, active-low: 0 at a rising edge resets the block.
- start, in, 1, one-cycle request to begin a dump; sampled only in IDLE.
- busy, out, 1, high from the cycle after an accepted start until done.
- done, out, 1, one-cycle pulse after the final beat handshakes.
- mem_re, out, 1, read strobe to the data-memory read port.
- mem_addr, out, ADDR_W, byte address for the read; word-aligned.
- mem_rdata, in, DATA_W, read data; valid exactly one cycle after mem_re.
- out_valid, out, 1, stream beat valid.
- out_ready, in, 1, downstream accepts the beat.
- out_addr, out, ADDR_W, byte address of the beat's word.
- out_data, out, DATA_W, word contents.
- out_last, out, 1, high on the beat for word WORDS-1.

Behaviour:
- Reset (reset=0): state IDLE; index=0; busy, done, mem_re, out_valid and out_last = 0; mem_addr=BASE; out_addr and out_data = 0. Reset mid-dump aborts at once, with no done pulse and no further beats.
- States: IDLE, READ, CAPTURE, SEND, FINISH.
- IDLE: start=1 -> READ; index=0. start in any other state is ignored.
- READ: mem_re=1 for exactly one cycle; mem_addr = BASE + 4*index, computed modulo 2^ADDR_W. Next state is CAPTURE.
- CAPTURE: register mem_rdata into out_data and mem_addr into out_addr. Set out_last = (index == WORDS-1). Next state is SEND with out_valid=1.
- SEND: out_valid, out_addr, out_data and out_last hold stable until out_ready=1 at a clock edge (AXI-style rule: valid never drops without a handshake; ready may be high early).
  - On handshake with out_last=0: index+1, go to READ, out_valid=0.
  - On handshake with out_last=1: go to FINISH, out_valid=0.
- FINISH: done=1 for one cycle, busy=0 next cycle, return to IDLE.
- busy is 1 in READ, CAPTURE, SEND and FINISH, and 0 in IDLE. done=1 only in FINISH.
- Latency and throughput:
  - start to first out_valid: 3 cycles (IDLE edge, READ, CAPTURE).
  - Steady state with out_ready tied high: one beat every 3 cycles.
  - Full dump with ready high: 3*WORDS+1 cycles from start to done.
- mem_re is never asserted outside READ. The block never writes memory.
- Index counter width is clog2(WORDS)+1; no wrap within a dump.
- start coincident with the FINISH->IDLE transition is ignored. A new start is accepted from the first IDLE cycle onward.

Decomposition:
- Shared package dmem_dump_pkg holds:
  - the state enum (IDLE, READ, CAPTURE, SEND, FINISH);
  - the WORD_BYTES=4 constant;
  - the byte-address-of-index function, for reuse by the bench model.
- One natural sub-module, stream_hold_reg: the valid/ready output register (load, hold-until-ready, clear). All other logic is flat.

Test Plan:
- Pre-load RAM[i]=0xA5000000+i, WORDS=64, BASE=0, out_ready=1, pulse start -> 64 beats: out_addr=4*i, out_data=0xA5000000+i; out_last only on beat 63 (addr 0xFC); done pulses 193 cycles after start.
- Backpressure: out_ready random, 30% high -> out_valid never drops unaccepted, data stable while stalled, beat order and count unchanged; at most one mem_re per beat.
- BASE=0x40, WORDS=1 -> single beat: addr 0x40, out_last=1, mem_re exactly once, done one cycle after the handshake.
- reset=0 asserted in SEND of beat 10 -> the next cycle shows out_valid=0, busy=0, no done. A fresh start then dumps from index 0.
- start pulsed repeatedly while busy -> ignored, exactly WORDS beats. start held high across FINISH -> accepted only in IDLE, second dump begins after done.
- Core integration: run the program, then dump -> stream contents equal the $writememh image of data memory words 0..63.
